// File: rtl/tone_period_meter.sv
// Half-period meter for an asynchronous square wave: glitch filter, loss-of-tone timeout, lock flag.
// Optional 4-sample averaging of period_out is enabled by defining TONE_METER_AVG_EN.
module tone_period_meter #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned TIMEOUT    = 16777215
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             square_wave_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic             tone_present,
    output logic             locked
);

    localparam int unsigned CW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOST  = 2'd3
    } state_e;

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             present_q;
    logic             locked_q;

    logic             edge_c;
    logic             accept_c;
    logic             timeout_c;
    logic             emit_c;
    logic             track_exit_c;
    logic             close_c;
    logic [CW-1:0]    cnt_inc_c;
    logic [WIDTH-1:0] sample_c;
    logic [WIDTH-1:0] diff_c;

    // Sample is cycles since the last accepted edge; held at all-ones once the counter saturates.
    assign cnt_inc_c    = CW'(cnt_q) + CW'(1);
    assign sample_c     = (&cnt_q) ? cnt_q : cnt_inc_c[WIDTH-1:0];
    assign edge_c       = s2_q ^ s3_q;
    assign accept_c     = edge_c && ((state_q == ST_IDLE) || (state_q == ST_LOST) ||
                                     (cnt_inc_c >= CW'(MIN_PERIOD)));
    assign timeout_c    = (cnt_inc_c == CW'(TIMEOUT));
    assign emit_c       = accept_c && ((state_q == ST_ARMED) || (state_q == ST_TRACK));
    assign track_exit_c = (state_q == ST_TRACK) && !accept_c && timeout_c;
    assign diff_c       = (sample_c >= prev_q) ? (sample_c - prev_q) : (prev_q - sample_c);
    assign close_c      = (diff_c <= WIDTH'(1));

    // Synchronizer, edge history and interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= square_wave_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (accept_c) begin
                cnt_q <= '0;
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + WIDTH'(1);
            end
        end
    end

    // Tracking state machine with registered presence and lock flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            present_q <= 1'b0;
            locked_q  <= 1'b0;
            prev_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOST: begin
                    if (accept_c) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (accept_c) begin
                        state_q   <= ST_TRACK;
                        present_q <= 1'b1;
                        prev_q    <= sample_c;
                        locked_q  <= 1'b0;
                    end else if (timeout_c) begin
                        state_q <= ST_LOST;
                    end
                end
                ST_TRACK: begin
                    if (accept_c) begin
                        prev_q   <= sample_c;
                        locked_q <= close_c;
                    end else if (timeout_c) begin
                        state_q   <= ST_LOST;
                        present_q <= 1'b0;
                        locked_q  <= 1'b0;
                        prev_q    <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TONE_METER_AVG_EN
    logic [WIDTH-1:0] h0_q, h1_q, h2_q;
    logic [1:0]       hcnt_q;
    logic [SW-1:0]    sum_c;
    logic             avg_ready_c;

    assign sum_c       = SW'(sample_c) + SW'(h0_q) + SW'(h1_q) + SW'(h2_q);
    assign avg_ready_c = emit_c && (hcnt_q == 2'd3);

    // Last three raw samples since entering TRACK; hcnt saturates once three are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_q   <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            hcnt_q <= 2'd0;
        end else if (track_exit_c) begin
            h0_q   <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            hcnt_q <= 2'd0;
        end else if (emit_c) begin
            h0_q <= sample_c;
            h1_q <= h0_q;
            h2_q <= h1_q;
            if (hcnt_q != 2'd3) begin
                hcnt_q <= hcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= avg_ready_c;
            if (avg_ready_c) begin
                period_q <= sum_c[WIDTH+1:2];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= emit_c;
            if (emit_c) begin
                period_q <= sample_c;
            end
        end
    end
`endif

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign tone_present = present_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomized and directed bench for tone_period_meter against a timestamp-based reference model.
module tb_tone_period_meter;

    localparam int unsigned W       = 24;
    localparam int unsigned MINP    = 4;
    localparam int unsigned TMO     = 1000;

    logic         clk;
    logic         rst_n;
    logic         square_wave_in;
    logic [W-1:0] period_out;
    logic         period_valid;
    logic         tone_present;
    logic         locked;

    tone_period_meter #(
        .WIDTH      (W),
        .MIN_PERIOD (MINP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .square_wave_in (square_wave_in),
        .period_out     (period_out),
        .period_valid   (period_valid),
        .tone_present   (tone_present),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    int unsigned total;
    int unsigned bad;
    bit          lvl;

    // Reference model: time-stamps of accepted edges instead of a counter.
    longint      cyc;
    longint      m_last;
    int          m_phase;      // 0 idle, 1 armed, 2 track, 3 lost
    bit          m_s1, m_s2, m_s3;
    longint      m_prev;
    longint      m_hist[$];
    logic [W-1:0] e_period;
    logic         e_valid;
    logic         e_present;
    logic         e_locked;

    task automatic model_reset();
        m_last    = cyc;
        m_phase   = 0;
        m_s1      = 0;
        m_s2      = 0;
        m_s3      = 0;
        m_prev    = 0;
        m_hist.delete();
        e_period  = '0;
        e_valid   = 0;
        e_present = 0;
        e_locked  = 0;
    endtask

    task automatic model_emit(input longint s);
`ifdef TONE_METER_AVG_EN
        m_hist.push_back(s);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) begin
            e_period = W'((m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4);
            e_valid  = 1;
        end
`else
        e_period = W'(s);
        e_valid  = 1;
`endif
    endtask

    task automatic model_step(input bit din);
        bit     edge_seen;
        bit     acc;
        longint since;
        cyc++;
        edge_seen = m_s2 ^ m_s3;
        m_s3 = m_s2;
        m_s2 = m_s1;
        m_s1 = din;
        since   = cyc - m_last;
        e_valid = 0;
        acc = edge_seen && (m_phase == 0 || m_phase == 3 || since >= MINP);
        if (acc) begin
            m_last = cyc;
            if (m_phase == 0 || m_phase == 3) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase  = 2;
                e_locked = 0;
                m_prev   = since;
                model_emit(since);
            end else begin
                e_locked = ((since > m_prev) ? since - m_prev : m_prev - since) <= 1;
                m_prev   = since;
                model_emit(since);
            end
        end else if ((m_phase == 1 || m_phase == 2) && since == TMO) begin
            m_phase  = 3;
            e_locked = 0;
            m_prev   = 0;
            m_hist.delete();
        end
        e_present = (m_phase == 2);
    endtask

    // One clock: drive input before the edge, update model, sample 1 time unit after the edge.
    task automatic tick(input bit v);
        square_wave_in = v;
        @(posedge clk);
        if (!rst_n) begin
            cyc++;
            model_reset();
        end else begin
            model_step(v);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            tick(bit'(i & 1));
            total++;
            if ({period_out, period_valid, tone_present, locked} !== {W'(0), 3'b000}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc,
                         {period_out, period_valid, tone_present, locked});
            end
        end
        lvl = 0;
        tick(0);
        rst_n = 1;
    endtask

    task automatic test_basic();
        int pulses;
        pulses = 0;
        for (int s = 0; s < 6; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < 10; k++) begin
                tick(lvl);
                pulses += int'(period_valid);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL basic cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
        total++;
        if (pulses != 5 || period_out !== W'(10) || tone_present !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL basic_final pulses=%0d p=%0d t=%0b l=%0b exp 5/10/1/1",
                     pulses, period_out, tone_present, locked);
        end
    endtask

    task automatic test_glitch();
        for (int s = 0; s < 4; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < 10; k++) begin
                tick((s == 1 && k == 2) ? ~lvl : lvl);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
        total++;
        if (period_out !== W'(10) || locked !== 1'b1) begin
            bad++;
            $display("FAIL glitch_final p=%0d l=%0b exp 10/1", period_out, locked);
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 1010; k++) begin
            tick(lvl);
            total++;
            if ({period_out, period_valid, tone_present, locked} !==
                {e_period, e_valid, e_present, e_locked}) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc,
                         {period_out, period_valid, tone_present, locked},
                         {e_period, e_valid, e_present, e_locked});
            end
        end
        total++;
        if (tone_present !== 1'b0 || locked !== 1'b0 || period_out !== W'(10)) begin
            bad++;
            $display("FAIL timeout_final t=%0b l=%0b p=%0d exp 0/0/10", tone_present, locked, period_out);
        end
        for (int s = 0; s < 3; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < 12; k++) begin
                tick(lvl);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL rearm cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
        total++;
        if (tone_present !== 1'b1 || period_out !== W'(12)) begin
            bad++;
            $display("FAIL rearm_final t=%0b p=%0d exp 1/12", tone_present, period_out);
        end
    endtask

    task automatic test_freq_change();
        int lens[7] = '{10, 10, 25, 25, 26, 25, 26};
        for (int s = 0; s < 7; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < lens[s]; k++) begin
                tick(lvl);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL freq_change cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
        total++;
        if (locked !== 1'b1 || period_out !== W'(25)) begin
            bad++;
            $display("FAIL freq_change_final l=%0b p=%0d exp 1/25", locked, period_out);
        end
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 60; s++) begin
            len = ($urandom_range(0, 19) == 0) ? 1000 + int'($urandom_range(0, 20))
                                               : int'($urandom_range(1, 30));
            lvl = ~lvl;
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL random cyc=%0d len=%0d got=%h exp=%h", cyc, len,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 4; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < 12; k++) tick(lvl);
        end
        lvl = ~lvl;
        tick(lvl);
        tick(lvl);
        total++;
        if (tone_present !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre t=%0b exp 1", tone_present);
        end
        rst_n = 0;
        #1;
        model_reset();
        total++;
        if ({period_out, period_valid, tone_present, locked} !== {W'(0), 3'b000}) begin
            bad++;
            $display("FAIL reset_mid_async got=%h exp=0", {period_out, period_valid, tone_present, locked});
        end
        tick(lvl);
        tick(lvl);
        rst_n = 1;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 15; k++) begin
                tick(lvl);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL reset_mid_recover cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
            lvl = ~lvl;
        end
    endtask

`ifdef TONE_METER_AVG_EN
    task automatic test_average();
        int lens[5] = '{10, 10, 10, 14, 10};
        int pulses;
        pulses = 0;
        lvl   = 0;
        rst_n = 0;
        tick(0);
        tick(0);
        rst_n = 1;
        for (int s = 0; s < 5; s++) begin
            lvl = ~lvl;
            for (int k = 0; k < lens[s]; k++) begin
                tick(lvl);
                pulses += int'(period_valid);
                total++;
                if ({period_out, period_valid, tone_present, locked} !==
                    {e_period, e_valid, e_present, e_locked}) begin
                    bad++;
                    $display("FAIL average cyc=%0d got=%h exp=%h", cyc,
                             {period_out, period_valid, tone_present, locked},
                             {e_period, e_valid, e_present, e_locked});
                end
            end
        end
        total++;
        if (pulses != 1 || period_out !== W'(11)) begin
            bad++;
            $display("FAIL average_final pulses=%0d p=%0d exp 1/11", pulses, period_out);
        end
    endtask
`endif

    initial begin
        clk            = 0;
        rst_n          = 0;
        square_wave_in = 0;
        lvl            = 0;
        total          = 0;
        bad            = 0;
        cyc            = 0;
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_timeout();
        test_freq_change();
        test_random();
        test_reset_mid();
`ifdef TONE_METER_AVG_EN
        test_average();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
